rem3_sched: RTL and testbench



---
 rtl/rem3_sched_pkg.sv | 28 ++
 rtl/rem3_sched_if.sv | 25 ++
 rtl/rem3_step.sv | 27 ++
 rtl/rem3_sched.sv | 106 ++++++++++
 tb/tb_rem3_sched.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/rem3_sched_pkg.sv
// Shared definitions for the serial mod-3 residue blocks: residue codes,
// scheduler state encoding and the single-bit residue update.
package rem_pkg;

    localparam logic [1:0] R0 = 2'b00;
    localparam logic [1:0] R1 = 2'b01;
    localparam logic [1:0] R2 = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Appending one bit MSB-first doubles the value, so next = (2*r + b) mod 3.
    // The unused code 2'b11 falls back to R0.
    function automatic logic [1:0] mod3_next(input logic [1:0] residue, input logic b);
        logic [1:0] nxt;
        case (residue)
            R0:      nxt = b ? R1 : R0;
            R1:      nxt = b ? R0 : R2;
            R2:      nxt = b ? R2 : R1;
            default: nxt = R0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rem3_sched_if.sv
// Request/result bundle of the mod-3 scheduler; the slave side is the scheduler.
interface rem3_sched_if #(parameter int WIDTH = 8);

    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [1:0]       req_ready;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [1:0]       res_rem;
    logic             res_div;
    logic             busy;

    modport master (
        output req_valid, req_data0, req_data1, res_ready,
        input  req_ready, res_valid, res_id, res_rem, res_div, busy
    );

    modport slave (
        input  req_valid, req_data0, req_data1, res_ready,
        output req_ready, res_valid, res_id, res_rem, res_div, busy
    );

endinterface

// File: rtl/rem3_step.sv
// Registered serial mod-3 residue engine; one bit per enabled clock, clear wins.
module rem3_step
    import rem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       x,
    output logic [1:0] residue
);

    logic [1:0] r_residue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_residue <= R0;
        end else if (clr) begin
            r_residue <= R0;
        end else if (en) begin
            r_residue <= mod3_next(r_residue, x);
        end
    end

    assign residue = r_residue;

endmodule

// File: rtl/rem3_sched.sv
// Two-requester round-robin front end that feeds words MSB-first through a
// shared serial mod-3 engine and returns remainder, divisibility and owner.
module rem3_sched
    import rem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    rem3_sched_if.slave   bus
);

    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNTW-1:0]  r_cnt;
    logic             r_last_grant;
    logic             r_res_id;
    logic [1:0]       r_res_rem;
    logic             r_res_div;

    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_last_bit;
    logic [1:0]       w_residue;
    logic [1:0]       w_final_res;

    // Grant is only offered in IDLE; on a tie the requester not served last wins.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == ST_IDLE) begin
            case (bus.req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_accept    = |(bus.req_valid & w_grant);
    assign w_last_bit  = (r_cnt == CNTW'(1));
    assign w_final_res = mod3_next(w_residue, r_shift[WIDTH-1]);

    rem3_step u_step (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_accept),
        .en      (r_state == ST_SHIFT),
        .x       (r_shift[WIDTH-1]),
        .residue (w_residue)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_res_id     <= 1'b0;
            r_res_rem    <= R0;
            r_res_div    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift      <= w_grant[1] ? bus.req_data1 : bus.req_data0;
                        r_cnt        <= CNTW'(WIDTH);
                        r_res_id     <= w_grant[1];
                        r_last_grant <= w_grant[1];
                        r_state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - CNTW'(1);
                    // Result registers only move here so they hold outside DONE.
                    if (w_last_bit) begin
                        r_res_rem <= w_final_res;
                        r_res_div <= (w_final_res == R0);
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.res_valid = (r_state == ST_DONE);
    assign bus.res_id    = r_res_id;
    assign bus.res_rem   = r_res_rem;
    assign bus.res_div   = r_res_div;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rem3_sched.sv
// Directed bench for rem3_sched: a cycle-level reference of the scheduling
// rules checked every cycle, plus literal expectations per scenario.
module tb_rem3_sched;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;

    rem3_sched_if #(.WIDTH(WIDTH)) bus ();

    rem3_sched #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 working, 2 result pending.
    int         m_phase;
    int         m_cnt;
    logic [WIDTH-1:0] m_word;
    logic       m_last;
    logic       m_id;
    logic [1:0] m_rem;
    logic       m_div;

    function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
        if (v == 2'b01) return 2'b01;
        if (v == 2'b10) return 2'b10;
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_word = '0;
            m_last = 1'b1; m_id = 1'b0; m_rem = 2'd0; m_div = 1'b0;
        end else begin
            logic [1:0] g;
            case (m_phase)
                0: begin
                    g = model_grant(bus.req_valid, m_last);
                    if (g != 2'b00) begin
                        m_id    = g[1];
                        m_last  = g[1];
                        m_word  = g[1] ? bus.req_data1 : bus.req_data0;
                        m_cnt   = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == WIDTH) begin
                        m_rem   = 2'(m_word % 3);
                        m_div   = (m_word % 3 == 0);
                        m_phase = 2;
                    end
                end
                default: if (bus.res_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("req_ready", 32'(bus.req_ready),
              (m_phase == 0 && !rst) ? 32'(model_grant(bus.req_valid, m_last)) : 32'd0);
        check("res_valid", 32'(bus.res_valid), 32'(m_phase == 2));
        check("busy",      32'(bus.busy),      32'(m_phase != 0));
        check("res_id",    32'(bus.res_id),    32'(m_id));
        check("res_rem",   32'(bus.res_rem),   32'(m_rem));
        check("res_div",   32'(bus.res_div),   32'(m_div));
    end

    task automatic wait_accept(input string name);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.busy) return;
        end
        check({name, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.res_valid) return;
        end
        lat = -1;
    endtask

    task automatic run_job(input string name, input logic [1:0] v, input logic [WIDTH-1:0] d0,
                           input logic [WIDTH-1:0] d1, input bit hold,
                           input logic exp_id, input logic [1:0] exp_rem);
        int lat;
        bus.req_valid = v;
        bus.req_data0 = d0;
        bus.req_data1 = d1;
        wait_accept(name);
        if (!hold) bus.req_valid = 2'b00;
        wait_result(lat);
        check({name, "_latency"}, 32'(lat), 32'(WIDTH));
        check({name, "_id"},  32'(bus.res_id),  32'(exp_id));
        check({name, "_rem"}, 32'(bus.res_rem), 32'(exp_rem));
        check({name, "_div"}, 32'(bus.res_div), 32'(exp_rem == 2'd0));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_data0 = '0;
        bus.req_data1 = '0;
        bus.res_ready = 1'b1;
        #2;
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_res_rem",   32'(bus.res_rem),   32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Divisible word, then remainders 1, 2, 0.
        run_job("div9",  2'b01, 8'd9,   8'd0, 1'b0, 1'b0, 2'd0);
        run_job("rem10", 2'b01, 8'd10,  8'd0, 1'b0, 1'b0, 2'd1);
        run_job("rem2",  2'b01, 8'd2,   8'd0, 1'b0, 1'b0, 2'd2);
        run_job("remFF", 2'b01, 8'hFF,  8'd0, 1'b0, 1'b0, 2'd0);

        // Tie after reset: requester 0 first, then strict alternation.
        pulse_reset();
        for (int j = 0; j < 6; j++) begin
            run_job($sformatf("arb%0d", j), 2'b11, 8'd4, 8'd6, 1'b1,
                    1'(j % 2), (j % 2 == 0) ? 2'd1 : 2'd0);
        end
        bus.req_valid = 2'b00;
        @(posedge clk); #1;

        // Backpressure in DONE with a waiting requester 1.
        bus.res_ready = 1'b0;
        run_job("bp", 2'b01, 8'd11, 8'd7, 1'b0, 1'b0, 2'd2);
        bus.req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(bus.res_valid), 32'd1);
            check("bp_hold_rem",   32'(bus.res_rem),   32'd2);
            check("bp_hold_id",    32'(bus.res_id),    32'd0);
            check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released_valid", 32'(bus.res_valid), 32'd0);
        check("bp_waiting_grant",  32'(bus.req_ready), 32'd2);
        run_job("bp_next", 2'b10, 8'd11, 8'd7, 1'b0, 1'b1, 2'd1);
        @(posedge clk); #1;

        // Asynchronous reset in the third SHIFT cycle discards the job.
        bus.req_valid = 2'b01;
        bus.req_data0 = 8'd5;
        wait_accept("mid");
        bus.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(bus.busy),      32'd0);
        check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_id",    32'(bus.res_id),    32'd0);
        check("mid_rst_rem",   32'(bus.res_rem),   32'd0);
        check("mid_rst_div",   32'(bus.res_div),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("mid_no_result", 32'(bus.res_valid), 32'd0);
        end
        run_job("post_rst_tie", 2'b11, 8'd8, 8'd3, 1'b0, 1'b0, 2'd2);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
